// File: rtl/exc_commit_ctrl.sv
// Exception / ertn commit sequencer between WB, the CSR file and pre-IF.
// Ports: WB event flags in, CSR commit strobes out, pre-IF redirect handshake out.
module exc_commit_ctrl #(
    parameter int DRAIN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        wb_int,
    input  logic        wb_adef,
    input  logic        wb_ine,
    input  logic        wb_sys,
    input  logic        wb_brk,
    input  logic        wb_ale,
    input  logic        wb_ertn,
    output logic        wb_commit_ok,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_pc,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_epc,
    output logic        wb_badv_we,
    output logic [31:0] wb_badv,
    output logic        ertn_flush,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        REDIRECT,
        DRAIN
    } state_t;

    localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

    state_t      state_q;
    state_t      state_d;
    logic        is_ertn_q;
    logic        badv_en_q;
    logic [3:0]  drain_q;

    logic        any_exc;
    logic        wb_event;
    logic [5:0]  ecode_sel;
    logic        badv_en_sel;
    logic [31:0] badv_sel;

    assign any_exc  = wb_int | wb_adef | wb_ine | wb_sys | wb_brk | wb_ale;
    assign wb_event = wb_valid & (any_exc | wb_ertn);

    // Several flags may be set at once; only the highest-priority one wins.
    always_comb begin
        ecode_sel   = 6'h00;
        badv_en_sel = 1'b0;
        badv_sel    = 32'h0;
        priority case (1'b1)
            wb_int:  ecode_sel = 6'h00;
            wb_adef: begin
                ecode_sel   = 6'h08;
                badv_en_sel = 1'b1;
                badv_sel    = wb_pc;
            end
            wb_ine:  ecode_sel = 6'h0D;
            wb_sys:  ecode_sel = 6'h0B;
            wb_brk:  ecode_sel = 6'h0C;
            wb_ale:  begin
                ecode_sel   = 6'h09;
                badv_en_sel = 1'b1;
                badv_sel    = wb_vaddr;
            end
            default: ecode_sel = 6'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (wb_event) state_d = COMMIT;
            COMMIT:   state_d = REDIRECT;
            REDIRECT: begin
                if (redirect_ready)
                    state_d = (DRAIN_LD != 4'd0) ? DRAIN : IDLE;
            end
            DRAIN:    if (drain_q <= 4'd1) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_ertn_q   <= 1'b0;
            badv_en_q   <= 1'b0;
            drain_q     <= 4'd0;
            wb_ecode    <= 6'h00;
            wb_epc      <= 32'h0;
            wb_badv     <= 32'h0;
            redirect_pc <= 32'h0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (wb_event) begin
                        // ertn only wins when no exception flag is set
                        is_ertn_q <= ~any_exc;
                        badv_en_q <= any_exc & badv_en_sel;
                        wb_ecode  <= any_exc ? ecode_sel : 6'h00;
                        wb_epc    <= wb_pc;
                        wb_badv   <= any_exc ? badv_sel : 32'h0;
                    end
                end
                // Sampled before the CSR write from this strobe lands.
                COMMIT:   redirect_pc <= is_ertn_q ? ertn_pc : ex_entry;
                REDIRECT: if (redirect_ready) drain_q <= DRAIN_LD;
                DRAIN:    if (drain_q != 4'd0) drain_q <= drain_q - 4'd1;
                default:  ;
            endcase
        end
    end

    assign wb_esubcode    = 9'h000;
    assign wb_ex          = (state_q == COMMIT) & ~is_ertn_q;
    assign wb_badv_we     = (state_q == COMMIT) & ~is_ertn_q & badv_en_q;
    assign ertn_flush     = (state_q == COMMIT) & is_ertn_q;
    assign pipe_flush     = (state_q != IDLE);
    assign redirect_valid = (state_q == REDIRECT);
    assign wb_ready       = (state_q == IDLE);
    assign wb_commit_ok   = wb_valid & (state_q == IDLE) & ~wb_event;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: scoreboard of expected CSR commits plus
// per-scenario timing checks; extra instances cover drain lengths 0 and 15.
module tb_exc_commit_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic wb_valid, wb_int, wb_adef, wb_ine, wb_sys, wb_brk, wb_ale, wb_ertn;
    logic [31:0] wb_pc, wb_vaddr, ex_entry, ertn_pc;
    logic redirect_ready;

    logic wb_ready, wb_commit_ok, wb_ex, wb_badv_we, ertn_flush;
    logic pipe_flush, redirect_valid;
    logic [5:0] wb_ecode;
    logic [8:0] wb_esubcode;
    logic [31:0] wb_epc, wb_badv, redirect_pc;

    logic z_ready, z_ok, z_ex, z_bwe, z_ertn, z_flush, z_rv;
    logic [5:0] z_ecode;
    logic [8:0] z_sub;
    logic [31:0] z_epc, z_badv, z_rpc;

    logic f_ready, f_ok, f_ex, f_bwe, f_ertn, f_flush, f_rv;
    logic [5:0] f_ecode;
    logic [8:0] f_sub;
    logic [31:0] f_epc, f_badv, f_rpc;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        is_ertn;
        logic [5:0]  ecode;
        logic [31:0] epc;
        logic        badv_we;
        logic [31:0] badv;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    exc_commit_ctrl #(.DRAIN_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_int(wb_int),
        .wb_adef(wb_adef), .wb_ine(wb_ine), .wb_sys(wb_sys),
        .wb_brk(wb_brk), .wb_ale(wb_ale), .wb_ertn(wb_ertn),
        .wb_commit_ok(wb_commit_ok), .ex_entry(ex_entry), .ertn_pc(ertn_pc),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_epc(wb_epc), .wb_badv_we(wb_badv_we), .wb_badv(wb_badv),
        .ertn_flush(ertn_flush), .pipe_flush(pipe_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    exc_commit_ctrl #(.DRAIN_CYCLES(0)) dut_d0 (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(z_ready),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_int(wb_int),
        .wb_adef(wb_adef), .wb_ine(wb_ine), .wb_sys(wb_sys),
        .wb_brk(wb_brk), .wb_ale(wb_ale), .wb_ertn(wb_ertn),
        .wb_commit_ok(z_ok), .ex_entry(ex_entry), .ertn_pc(ertn_pc),
        .wb_ex(z_ex), .wb_ecode(z_ecode), .wb_esubcode(z_sub),
        .wb_epc(z_epc), .wb_badv_we(z_bwe), .wb_badv(z_badv),
        .ertn_flush(z_ertn), .pipe_flush(z_flush),
        .redirect_valid(z_rv), .redirect_pc(z_rpc),
        .redirect_ready(redirect_ready)
    );

    exc_commit_ctrl #(.DRAIN_CYCLES(15)) dut_d15 (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(f_ready),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_int(wb_int),
        .wb_adef(wb_adef), .wb_ine(wb_ine), .wb_sys(wb_sys),
        .wb_brk(wb_brk), .wb_ale(wb_ale), .wb_ertn(wb_ertn),
        .wb_commit_ok(f_ok), .ex_entry(ex_entry), .ertn_pc(ertn_pc),
        .wb_ex(f_ex), .wb_ecode(f_ecode), .wb_esubcode(f_sub),
        .wb_epc(f_epc), .wb_badv_we(f_bwe), .wb_badv(f_badv),
        .ertn_flush(f_ertn), .pipe_flush(f_flush),
        .redirect_valid(f_rv), .redirect_pc(f_rpc),
        .redirect_ready(redirect_ready)
    );

    // Scoreboard: every CSR commit strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (wb_ex || ertn_flush)) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got wb_ex=%b ertn_flush=%b expected no strobe",
                         wb_ex, ertn_flush);
            end else begin
                e = sb.pop_front();
                if (wb_ex !== !e.is_ertn || ertn_flush !== e.is_ertn ||
                    wb_esubcode !== 9'h0 ||
                    (!e.is_ertn && (wb_ecode !== e.ecode || wb_epc !== e.epc ||
                     wb_badv_we !== e.badv_we ||
                     (e.badv_we && wb_badv !== e.badv))))
                    $display("FAIL sb_commit: got ex=%b ertn=%b ecode=%h sub=%h epc=%h bwe=%b badv=%h expected ertn=%b ecode=%h epc=%h bwe=%b badv=%h",
                             wb_ex, ertn_flush, wb_ecode, wb_esubcode, wb_epc,
                             wb_badv_we, wb_badv, e.is_ertn, e.ecode, e.epc,
                             e.badv_we, e.badv);
                else
                    passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        wb_valid = 0; wb_int = 0; wb_adef = 0; wb_ine = 0;
        wb_sys = 0; wb_brk = 0; wb_ale = 0; wb_ertn = 0;
    endtask

    task automatic push_exp(input logic er, input logic [5:0] ec,
                            input logic [31:0] pc, input logic bwe,
                            input logic [31:0] bv);
        exp_t x;
        x.is_ertn = er; x.ecode = ec; x.epc = pc; x.badv_we = bwe; x.badv = bv;
        sb.push_back(x);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && !wb_ready; i++) tick();
        checks++;
        if (wb_ready !== 1'b1) $display("FAIL wait_idle: got wb_ready=%b expected 1", wb_ready);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1; clear_in();
        wb_pc = 0; wb_vaddr = 0; ex_entry = 0; ertn_pc = 0; redirect_ready = 1;
        tick(); tick();
        checks++;
        if ({wb_ex, ertn_flush, wb_badv_we, pipe_flush, redirect_valid, wb_ready} !== 6'b000001 ||
            wb_ecode !== 0 || wb_epc !== 0 || wb_badv !== 0 || redirect_pc !== 0)
            $display("FAIL reset: got ex=%b ertn=%b bwe=%b flush=%b rv=%b rdy=%b ecode=%h epc=%h badv=%h rpc=%h expected all 0 rdy=1",
                     wb_ex, ertn_flush, wb_badv_we, pipe_flush, redirect_valid,
                     wb_ready, wb_ecode, wb_epc, wb_badv, redirect_pc);
        else passed++;
        rst = 0;
        tick();
    endtask

    task automatic test_sys();
        wb_valid = 1; wb_sys = 1; wb_pc = 32'h1C000010; ex_entry = 32'h1C008000;
        redirect_ready = 1;
        push_exp(0, 6'h0B, 32'h1C000010, 0, 0);
        #1;
        checks++;
        if (wb_commit_ok !== 0) $display("FAIL sys_commit_ok: got %b expected 0", wb_commit_ok);
        else passed++;
        tick(); clear_in();
        checks++;
        if (wb_ex !== 1 || wb_badv_we !== 0 || pipe_flush !== 1 || redirect_valid !== 0)
            $display("FAIL sys_t1: got ex=%b bwe=%b flush=%b rv=%b expected 1 0 1 0",
                     wb_ex, wb_badv_we, pipe_flush, redirect_valid);
        else passed++;
        tick();
        checks++;
        if (redirect_valid !== 1 || redirect_pc !== 32'h1C008000 || wb_ex !== 0)
            $display("FAIL sys_t2: got rv=%b rpc=%h ex=%b expected 1 1c008000 0",
                     redirect_valid, redirect_pc, wb_ex);
        else passed++;
        tick();
        checks++;
        if (pipe_flush !== 1 || wb_ready !== 0)
            $display("FAIL sys_t3: got flush=%b rdy=%b expected 1 0", pipe_flush, wb_ready);
        else passed++;
        tick();
        checks++;
        if (pipe_flush !== 0 || wb_ready !== 1)
            $display("FAIL sys_t4: got flush=%b rdy=%b expected 0 1", pipe_flush, wb_ready);
        else passed++;
    endtask

    task automatic test_priority();
        logic [5:0] ecs [4];
        logic       bws [4];
        logic [31:0] bvs [4];
        ecs = '{6'h00, 6'h0D, 6'h08, 6'h09};
        bws = '{1'b0, 1'b0, 1'b1, 1'b1};
        bvs = '{32'h0, 32'h0, 32'h1C000020, 32'h00000003};
        redirect_ready = 1;
        for (int k = 0; k < 4; k++) begin
            clear_in();
            wb_valid = 1; wb_pc = 32'h1C000020; wb_vaddr = 32'h00000003;
            case (k)
                0: begin wb_int = 1; wb_ine = 1; wb_ale = 1; end
                1: begin wb_ine = 1; wb_ale = 1; end
                2: begin wb_adef = 1; wb_ale = 1; end
                default: wb_ale = 1;
            endcase
            push_exp(0, ecs[k], 32'h1C000020, bws[k], bvs[k]);
            tick(); clear_in();
            checks++;
            if (wb_ex !== 1 || wb_ecode !== ecs[k] || wb_badv_we !== bws[k])
                $display("FAIL prio_%0d: got ex=%b ecode=%h bwe=%b expected 1 %h %b",
                         k, wb_ex, wb_ecode, wb_badv_we, ecs[k], bws[k]);
            else passed++;
            wait_idle();
        end
    endtask

    task automatic test_ertn_stall();
        redirect_ready = 0;
        wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1C000200; ertn_pc = 32'h1C000100;
        push_exp(1, 6'h00, 32'h1C000200, 0, 0);
        tick(); clear_in();
        checks++;
        if (ertn_flush !== 1 || wb_ex !== 0 || wb_ready !== 0)
            $display("FAIL ertn_t1: got ertn=%b ex=%b rdy=%b expected 1 0 0",
                     ertn_flush, wb_ex, wb_ready);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            tick();
            ertn_pc = 32'hDEAD0000;
            checks++;
            if (redirect_valid !== 1 || redirect_pc !== 32'h1C000100 ||
                wb_ready !== 0 || ertn_flush !== 0)
                $display("FAIL ertn_hold_%0d: got rv=%b rpc=%h rdy=%b ertn=%b expected 1 1c000100 0 0",
                         i, redirect_valid, redirect_pc, wb_ready, ertn_flush);
            else passed++;
            if (i == 5) redirect_ready = 1;
        end
        tick();
        checks++;
        if (redirect_valid !== 0 || pipe_flush !== 1)
            $display("FAIL ertn_accept: got rv=%b flush=%b expected 0 1",
                     redirect_valid, pipe_flush);
        else passed++;
        wait_idle();
    endtask

    task automatic test_ertn_brk();
        int seen = 0;
        redirect_ready = 1;
        wb_valid = 1; wb_ertn = 1; wb_brk = 1; wb_pc = 32'h1C000300;
        push_exp(0, 6'h0C, 32'h1C000300, 0, 0);
        tick(); clear_in();
        checks++;
        if (wb_ex !== 1 || wb_ecode !== 6'h0C)
            $display("FAIL brk_ertn: got ex=%b ecode=%h expected 1 0c", wb_ex, wb_ecode);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            if (ertn_flush) seen++;
            tick();
        end
        checks++;
        if (seen != 0) $display("FAIL brk_no_ertn: got %0d ertn_flush cycles expected 0", seen);
        else passed++;
        wait_idle();
    endtask

    task automatic test_reset_redirect();
        redirect_ready = 0;
        wb_valid = 1; wb_sys = 1; wb_pc = 32'h1C000400;
        push_exp(0, 6'h0B, 32'h1C000400, 0, 0);
        tick(); clear_in();
        tick();
        checks++;
        if (redirect_valid !== 1)
            $display("FAIL rst_pre: got rv=%b expected 1", redirect_valid);
        else passed++;
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (redirect_valid !== 0 || pipe_flush !== 0 || wb_ready !== 1)
            $display("FAIL rst_mid: got rv=%b flush=%b rdy=%b expected 0 0 1",
                     redirect_valid, pipe_flush, wb_ready);
        else passed++;
        redirect_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (pipe_flush !== 0 || redirect_valid !== 0)
            $display("FAIL rst_after: got flush=%b rv=%b expected 0 0", pipe_flush, redirect_valid);
        else passed++;
    endtask

    task automatic test_drain_bounds();
        rst = 1; tick(); rst = 0; tick();
        redirect_ready = 1;
        wb_valid = 1; wb_brk = 1; wb_pc = 32'h1C000500;
        push_exp(0, 6'h0C, 32'h1C000500, 0, 0);
        tick(); clear_in();
        tick();
        checks++;
        if (z_rv !== 1 || f_rv !== 1)
            $display("FAIL drain_r: got rv0=%b rv15=%b expected 1 1", z_rv, f_rv);
        else passed++;
        tick();
        checks++;
        if (z_flush !== 0 || z_ready !== 1 || f_flush !== 1)
            $display("FAIL drain0: got flush0=%b rdy0=%b flush15=%b expected 0 1 1",
                     z_flush, z_ready, f_flush);
        else passed++;
        for (int k = 2; k <= 15; k++) tick();
        checks++;
        if (f_flush !== 1 || f_ready !== 0)
            $display("FAIL drain15_r15: got flush=%b rdy=%b expected 1 0", f_flush, f_ready);
        else passed++;
        tick();
        checks++;
        if (f_flush !== 0 || f_ready !== 1)
            $display("FAIL drain15_r16: got flush=%b rdy=%b expected 0 1", f_flush, f_ready);
        else passed++;
    endtask

    task automatic test_no_valid();
        int bad = 0;
        wb_valid = 0; wb_int = 1; wb_adef = 1; wb_ine = 1; wb_sys = 1;
        wb_brk = 1; wb_ale = 1; wb_ertn = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wb_ex || ertn_flush || pipe_flush || !wb_ready || wb_commit_ok) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL no_valid: got %0d active cycles expected 0", bad);
        else passed++;
        clear_in();
        wb_valid = 1;
        #1;
        checks++;
        if (wb_commit_ok !== 1) $display("FAIL commit_ok: got %b expected 1", wb_commit_ok);
        else passed++;
        tick();
        clear_in();
        tick();
    endtask

    initial begin
        test_reset();
        test_sys();
        test_priority();
        test_ertn_stall();
        test_ertn_brk();
        test_reset_redirect();
        test_drain_bounds();
        wait_idle();
        test_no_valid();
        checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
